spn_encrypt_core: RTL and testbench

- Iterative 64-bit PRESENT-80 substitution-permutation encryptor: one round per clock, 80-bit key.
- Forward companion to the 4-bit inverse-substitution decrypt path; produces the ciphertext that path consumes.
- Sits between the plaintext source and the link/storage layer, with a valid/ready handshake on each side.

---
 rtl/spn_encrypt_core.sv | 164 ++++++++++++++++
 tb/tb_spn_encrypt_core.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/spn_encrypt_core.sv
// -----------------------------------------------------------------------------
// spn_encrypt_core
//
// Iterative PRESENT-80 block encryptor. One full round per clock, 64-bit
// block, 80-bit key. A block is captured together with its key in IDLE, run
// through ROUNDS rounds, and the whitened ciphertext is presented until the
// consumer takes it.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset; aborts any block in flight
//   pt_valid  plaintext + key present
//   pt_ready  core can accept a block (high in IDLE only)
//   pt_data   64-bit plaintext
//   key       80-bit cipher key, sampled together with pt_data
//   ct_valid  ciphertext valid (high in DONE only)
//   ct_ready  consumer accepts the ciphertext
//   ct_data   64-bit ciphertext, zero whenever ct_valid is low
//   busy      high while a block is being processed or waiting in DONE
// -----------------------------------------------------------------------------
module spn_encrypt_core #(
  parameter int unsigned BLOCKSIZE = 4,
  parameter int unsigned ROUNDS    = 31
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pt_valid,
  output logic        pt_ready,
  input  logic [63:0] pt_data,
  input  logic [79:0] key,
  output logic        ct_valid,
  input  logic        ct_ready,
  output logic [63:0] ct_data,
  output logic        busy
);

  localparam int unsigned   NIBBLES  = 64 / BLOCKSIZE;
  localparam logic [4:0]    LAST_RND = 5'(ROUNDS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [63:0] st_reg;
  logic [79:0] key_reg;
  logic [4:0]  rnd;

  logic [63:0] st_next;
  logic [79:0] key_next;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [63:0] sbox_layer(input logic [63:0] s);
    logic [63:0] r;
    r = '0;
    for (int n = 0; n < int'(NIBBLES); n++) begin
      r[n*BLOCKSIZE +: 4] = sbox(s[n*BLOCKSIZE +: 4]);
    end
    return r;
  endfunction

  // Bit i lands at 16*i mod 63; bit 63 is the fixed point of the map.
  function automatic logic [63:0] p_layer(input logic [63:0] s);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 63; i++) begin
      r[(16*i) % 63] = s[i];
    end
    r[63] = s[63];
    return r;
  endfunction

  // Rotate left by 61 is the same as rotate right by 19 on 80 bits.
  function automatic logic [79:0] key_update(input logic [79:0] k,
                                             input logic [4:0]  rc);
    logic [79:0] kr;
    kr          = {k[18:0], k[79:19]};
    kr[79:76]   = sbox(kr[79:76]);
    kr[19:15]   = kr[19:15] ^ rc;
    return kr;
  endfunction

  always_comb begin
    st_next  = p_layer(sbox_layer(st_reg ^ key_reg[79:16]));
    key_next = key_update(key_reg, rnd);
  end

  // Outputs are registered; ct_data is loaded on the final round edge from the
  // next-state values so it already carries the closing key whitening.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      st_reg   <= '0;
      key_reg  <= '0;
      rnd      <= '0;
      pt_ready <= 1'b1;
      ct_valid <= 1'b0;
      ct_data  <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pt_valid) begin
            st_reg   <= pt_data;
            key_reg  <= key;
            rnd      <= 5'd1;
            state    <= RUN;
            pt_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          st_reg  <= st_next;
          key_reg <= key_next;
          if (rnd == LAST_RND) begin
            // Counter holds at the last round rather than wrapping.
            state    <= DONE;
            ct_valid <= 1'b1;
            ct_data  <= st_next ^ key_next[79:16];
          end else begin
            rnd <= rnd + 5'd1;
          end
        end
        DONE: begin
          if (ct_ready) begin
            state    <= IDLE;
            ct_valid <= 1'b0;
            ct_data  <= '0;
            busy     <= 1'b0;
            pt_ready <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          pt_ready <= 1'b1;
          ct_valid <= 1'b0;
          ct_data  <= '0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spn_encrypt_core.sv
module tb_spn_encrypt_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        pt_valid = 1'b0;
  logic        pt_ready;
  logic [63:0] pt_data = '0;
  logic [79:0] key = '0;
  logic        ct_valid;
  logic        ct_ready = 1'b0;
  logic [63:0] ct_data;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spn_encrypt_core #(.BLOCKSIZE(4), .ROUNDS(31)) dut (
    .clk(clk), .rst_n(rst_n),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data), .key(key),
    .ct_valid(ct_valid), .ct_ready(ct_ready), .ct_data(ct_data), .busy(busy)
  );

  // Reference cipher written straight from the algorithm description.
  logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                          4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  function automatic logic [63:0] present_model(input logic [63:0] p, input logic [79:0] k);
    logic [63:0] s, t;
    logic [79:0] kk;
    s = p;
    kk = k;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ kk[79:16];
      for (int j = 0; j < 16; j++) s[4*j +: 4] = SB[s[4*j +: 4]];
      t = '0;
      for (int i = 0; i < 64; i++) t[(i == 63) ? 63 : (i * 16) % 63] = s[i];
      s = t;
      kk = (kk << 61) | (kk >> 19);
      kk[79:76] = SB[kk[79:76]];
      kk[19:15] = kk[19:15] ^ r[4:0];
    end
    return s ^ kk[79:16];
  endfunction

  // Transaction-level expectation: idle / running for N edges / holding result.
  int          m_phase = 0;
  int          m_cnt = 0;
  logic [63:0] m_ct = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_cnt = 0;
      m_ct = '0;
    end else begin
      if (m_phase == 0) begin
        if (pt_valid) begin
          m_ct = present_model(pt_data, key);
          m_phase = 1;
          m_cnt = 0;
        end
      end else if (m_phase == 1) begin
        m_cnt++;
        if (m_cnt == 31) m_phase = 2;
      end else begin
        if (ct_ready) m_phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic        e_rdy, e_busy, e_vld;
    logic [63:0] e_ct;
    e_rdy  = (m_phase == 0);
    e_busy = (m_phase != 0);
    e_vld  = (m_phase == 2);
    e_ct   = (m_phase == 2) ? m_ct : 64'h0;
    checks++;
    if ({pt_ready, busy, ct_valid, ct_data} !== {e_rdy, e_busy, e_vld, e_ct}) begin
      failures++;
      $display("FAIL cycle_model t=%0t actual rdy=%b busy=%b vld=%b ct=%h required rdy=%b busy=%b vld=%b ct=%h",
               $time, pt_ready, busy, ct_valid, ct_data, e_rdy, e_busy, e_vld, e_ct);
    end
  end

  // Accept-edge timestamps, for the initiation-interval check.
  int cyc = 0;
  int accepts[$];
  always @(posedge clk) begin
    cyc++;
    if (pt_valid && pt_ready && rst_n) accepts.push_back(cyc);
  end

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check64(name, {60'h0, pt_ready, busy, ct_valid, 1'b0}, {60'h0, 1'b1, 1'b0, 1'b0, 1'b0});
    check64({name, "_ct"}, ct_data, 64'h0);
  endtask

  // Called at #1 after a rising edge with the core idle.
  task automatic run_block(input string name, input logic [63:0] p, input logic [79:0] k,
                           input logic [63:0] exp, input int bp, input bit junk);
    int n;
    check64({name, "_ready_before"}, {63'h0, pt_ready}, 64'h1);
    pt_valid = 1'b1;
    pt_data = p;
    key = k;
    ct_ready = 1'b0;
    @(posedge clk); #1;
    pt_valid = 1'b0;
    check64({name, "_ready_low"}, {62'h0, pt_ready, busy}, 64'h1);
    n = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (junk && (c == 5 || c == 20)) begin
        pt_valid = 1'b1;
        pt_data = 64'hDEAD_BEEF_0123_4567 ^ 64'(c);
        key = 80'h1234_5678_9ABC_DEF0_1111;
      end else begin
        pt_valid = 1'b0;
      end
      if (ct_valid) begin
        n = c;
        break;
      end
    end
    pt_valid = 1'b0;
    check64({name, "_latency"}, 64'(n), 64'd31);
    check64({name, "_ct"}, ct_data, exp);
    for (int b = 0; b < bp; b++) begin
      @(posedge clk); #1;
      check64({name, "_bp_hold"}, {ct_valid ? 64'h0 : 64'h1} ^ ct_data, exp);
    end
    ct_ready = 1'b1;
    @(posedge clk); #1;
    ct_ready = 1'b0;
    check64({name, "_idle_after"}, {61'h0, pt_ready, busy, ct_valid}, 64'h4);
  endtask

  initial begin
    // Pin the reference model to the published vectors.
    check64("model_zero",  present_model(64'h0, 80'h0), 64'h5579C1387B228445);
    check64("model_key1",  present_model(64'h0, {80{1'b1}}), 64'hE72C46C0F5945049);
    check64("model_pt1",   present_model({64{1'b1}}, 80'h0), 64'hA112FFC72F68417B);
    check64("model_both1", present_model({64{1'b1}}, {80{1'b1}}), 64'h3333DCD3213210D2);

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_block("zero",  64'h0, 80'h0, 64'h5579C1387B228445, 0, 1'b0);
    run_block("key1",  64'h0, {80{1'b1}}, 64'hE72C46C0F5945049, 0, 1'b0);
    run_block("pt1",   {64{1'b1}}, 80'h0, 64'hA112FFC72F68417B, 0, 1'b0);
    run_block("both1", {64{1'b1}}, {80{1'b1}}, 64'h3333DCD3213210D2, 10, 1'b0);
    run_block("junk",  64'h0, {80{1'b1}}, 64'hE72C46C0F5945049, 2, 1'b1);

    // Back-to-back: valid held high with the second block waiting.
    begin
      int base, got;
      base = accepts.size();
      pt_valid = 1'b1;
      pt_data = 64'h0;
      key = 80'h0;
      ct_ready = 1'b1;
      @(posedge clk); #1;
      pt_data = {64{1'b1}};
      key = {80{1'b1}};
      got = 0;
      for (int c = 0; c < 80; c++) begin
        if (accepts.size() >= base + 2) begin
          got = 1;
          break;
        end
        @(posedge clk); #1;
      end
      pt_valid = 1'b0;
      check64("b2b_second_accept", 64'(got), 64'h1);
      if (got == 1)
        check64("b2b_interval", 64'(accepts[base+1] - accepts[base]), 64'd33);
      got = 0;
      for (int c = 0; c < 60; c++) begin
        @(posedge clk); #1;
        if (ct_valid) begin
          got = 1;
          check64("b2b_second_ct", ct_data, 64'h3333DCD3213210D2);
          break;
        end
      end
      check64("b2b_second_done", 64'(got), 64'h1);
      @(posedge clk); #1;
      ct_ready = 1'b0;
    end

    // Asynchronous abort part-way through a block.
    pt_valid = 1'b1;
    pt_data = 64'h0;
    key = 80'h0;
    @(posedge clk); #1;
    pt_valid = 1'b0;
    repeat (12) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    repeat (3) @(posedge clk);
    #1;
    check64("reset_no_ct", {63'h0, ct_valid}, 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_block("after_reset", 64'h0, 80'h0, 64'h5579C1387B228445, 0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
